// File: rtl/dispatch.sv
`default_nettype none
// ============================================================================
// Module  : dispatch
// Purpose : Splits a kernel launch into blocks and hands each block to the
//           lowest-index free core. Define DISPATCH_PERF_CNT_EN to enable the
//           launch-to-done cycle counter on perf_cycles.
// Rev     : 1.0
// ============================================================================
module dispatch #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start,
  input  logic [7:0]                                         thread_count,
  input  logic [NUM_CORES-1:0]                               core_done,
  output logic [NUM_CORES-1:0]                               core_reset,
  output logic [NUM_CORES-1:0]                               core_start,
  output logic [NUM_CORES*8-1:0]                             core_block_id,
  output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0] core_thread_count,
  output logic                                               done,
  output logic [15:0]                                        perf_cycles
);

  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {L_FREE = 2'd0, L_RESET = 2'd1, L_BUSY = 2'd2} lane_t;

  state_t                   state_q, state_d;
  lane_t                    lane_q [NUM_CORES];
  lane_t                    lane_d [NUM_CORES];
  logic [7:0]               total_q, total_d;
  logic [7:0]               disp_q, disp_d;
  logic [7:0]               comp_q, comp_d;
  logic [TCW-1:0]           rem_q, rem_d;
  logic [NUM_CORES-1:0]     core_reset_q, core_reset_d;
  logic [NUM_CORES-1:0]     core_start_q, core_start_d;
  logic [NUM_CORES*8-1:0]   block_id_q, block_id_d;
  logic [NUM_CORES*TCW-1:0] tcount_q, tcount_d;
  logic                     done_q, done_d;
  logic                     found;
  logic [7:0]               n_fin;

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    total_d    = total_q;
    disp_d     = disp_q;
    comp_d     = comp_q;
    rem_d      = rem_q;
    block_id_d = block_id_q;
    tcount_d   = tcount_q;
    found      = 1'b0;
    n_fin      = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (thread_count == 8'd0) begin
            state_d = S_DONE;
          end else begin
            total_d = 8'((9'(thread_count) + 9'(THREADS_PER_BLOCK - 1)) / 9'(THREADS_PER_BLOCK));
            rem_d   = TCW'(thread_count % 8'(THREADS_PER_BLOCK));
            disp_d  = 8'd0;
            comp_d  = 8'd0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        for (int i = 0; i < NUM_CORES; i++) begin
          case (lane_q[i])
            L_RESET: lane_d[i] = L_BUSY;
            L_BUSY: begin
              if (core_done[i]) begin
                lane_d[i] = L_FREE;
                n_fin     = n_fin + 8'd1;
              end
            end
            L_FREE: begin
              // Priority to the lowest index; lanes freed this cycle are still BUSY here.
              if (!found && (disp_q < total_q)) begin
                found                   = 1'b1;
                lane_d[i]               = L_RESET;
                block_id_d[i*8 +: 8]    = disp_q;
                tcount_d[i*TCW +: TCW]  = ((disp_q == total_q - 8'd1) && (rem_q != '0))
                                          ? rem_q : TCW'(THREADS_PER_BLOCK);
                disp_d                  = disp_q + 8'd1;
              end
            end
            default: lane_d[i] = L_FREE;
          endcase
        end
        comp_d = comp_q + n_fin;
        if (comp_q == total_q) state_d = S_DONE;
      end
      S_DONE: begin
        // Guarantee at least one done cycle even if start already dropped in RUN.
        if (!start && done_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < NUM_CORES; i++) begin
      core_reset_d[i] = (lane_d[i] == L_RESET);
      core_start_d[i] = (lane_d[i] == L_BUSY);
    end
    done_d = (state_q == S_DONE) && (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < NUM_CORES; i++) lane_q[i] <= L_FREE;
      total_q      <= 8'd0;
      disp_q       <= 8'd0;
      comp_q       <= 8'd0;
      rem_q        <= '0;
      core_reset_q <= '0;
      core_start_q <= '0;
      block_id_q   <= '0;
      tcount_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      total_q      <= total_d;
      disp_q       <= disp_d;
      comp_q       <= comp_d;
      rem_q        <= rem_d;
      core_reset_q <= core_reset_d;
      core_start_q <= core_start_d;
      block_id_q   <= block_id_d;
      tcount_q     <= tcount_d;
      done_q       <= done_d;
    end
  end

  assign core_reset        = core_reset_q;
  assign core_start        = core_start_q;
  assign core_block_id     = block_id_q;
  assign core_thread_count = tcount_q;
  assign done              = done_q;

`ifdef DISPATCH_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && start) begin
      perf_d = 16'd0;
    end else if ((state_q == S_RUN) && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= 16'd0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch.sv
`default_nettype none
// Scoreboard bench for dispatch: expected dispatches and done events are queued
// at launch and matched by a negedge monitor against DUT activity.
module tb_dispatch;

  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int TCW = 3;
`ifdef DISPATCH_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        thread_count;
  logic [NC-1:0]     core_done;
  logic [NC-1:0]     core_reset;
  logic [NC-1:0]     core_start;
  logic [NC*8-1:0]   core_block_id;
  logic [NC*TCW-1:0] core_thread_count;
  logic              done;
  logic [15:0]       perf_cycles;

  dispatch #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .thread_count      (thread_count),
    .core_done         (core_done),
    .core_reset        (core_reset),
    .core_start        (core_start),
    .core_block_id     (core_block_id),
    .core_thread_count (core_thread_count),
    .done              (done),
    .perf_cycles       (perf_cycles)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int done_seen = 0;
  int delay [NC];
  int cnt   [NC];
  logic done_prev = 1'b0;

  typedef struct {int core; int blk; int tcnt; int rel;} disp_t;
  typedef struct {int rel; int perf;} done_t;
  disp_t exp_disp[$];
  done_t exp_done[$];
  disp_t ed;
  done_t en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int pexp(int v);
    return PERF_ON ? v : 0;
  endfunction

  task automatic exp_dispatch(int c, int b, int t, int r);
    disp_t d;
    d.core = c; d.blk = b; d.tcnt = t; d.rel = r;
    exp_disp.push_back(d);
  endtask

  task automatic exp_finish(int r, int p);
    done_t d;
    d.rel = r; d.perf = pexp(p);
    exp_done.push_back(d);
  endtask

  // Core model: done rises in the delay-th BUSY cycle, held until the next core_reset.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NC; i++) begin
      if (!reset || core_reset[i]) begin
        core_done[i] = 1'b0;
        cnt[i]       = 0;
      end else if (core_start[i] && !core_done[i]) begin
        cnt[i] = cnt[i] + 1;
        if (cnt[i] >= delay[i]) core_done[i] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) begin
        if (core_reset[i]) begin
          if (exp_disp.size() == 0) begin
            check("unexpected_dispatch_core", i, 32'hFFFF_FFFF);
          end else begin
            ed = exp_disp.pop_front();
            check("disp_core", i, ed.core);
            check("disp_block_id", core_block_id[i*8 +: 8], ed.blk);
            check("disp_thread_count", core_thread_count[i*TCW +: TCW], ed.tcnt);
            check("disp_cycle", cyc - t0, ed.rel);
          end
        end
      end
      if (done && !done_prev) begin
        done_seen++;
        if (exp_done.size() == 0) begin
          check("unexpected_done_cycle", cyc - t0, 32'hFFFF_FFFF);
        end else begin
          en = exp_done.pop_front();
          check("done_cycle", cyc - t0, en.rel);
          check("done_perf", perf_cycles, en.perf);
        end
      end
    end
    done_prev = done;
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic launch(int tc);
    start        = 1'b1;
    thread_count = 8'(tc);
    t0           = cyc;
  endtask

  task automatic wait_done(int target, int budget);
    int n = 0;
    while (done_seen < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("done_within_budget", done_seen >= target, 1);
  endtask

  task automatic check_queues(string name);
    check({name, "_pending_dispatch"}, exp_disp.size(), 0);
    check({name, "_pending_done"}, exp_done.size(), 0);
    exp_disp.delete();
    exp_done.delete();
  endtask

  task automatic check_all_zero(string name);
    check({name, "_core_reset"}, core_reset, 0);
    check({name, "_core_start"}, core_start, 0);
    check({name, "_block_id"}, core_block_id, 0);
    check({name, "_thread_count"}, core_thread_count, 0);
    check({name, "_done"}, done, 0);
    check({name, "_perf"}, perf_cycles, 0);
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    thread_count = 8'd0;
    core_done    = '0;
    delay[0] = 5; delay[1] = 5;
    cnt[0] = 0;   cnt[1] = 0;
    step(3);
    check_all_zero("reset");
    reset = 1'b1;
    step(2);

    // Two full blocks on two cores.
    exp_dispatch(0, 0, 4, 2);
    exp_dispatch(1, 1, 4, 3);
    exp_finish(11, 9);
    launch(8);
    wait_done(1, 60);
    start = 1'b0;
    step(2);
    check_queues("t8");

    // Partial last block goes to whichever core frees first (core 1 here).
    delay[0] = 6; delay[1] = 3;
    exp_dispatch(0, 0, 4, 2);
    exp_dispatch(1, 1, 4, 3);
    exp_dispatch(1, 2, 2, 8);
    exp_finish(14, 12);
    launch(10);
    wait_done(2, 60);
    start = 1'b0;
    step(2);
    check_queues("t10");

    // Zero threads, then hold start in DONE and try to relaunch.
    exp_finish(2, 0);
    launch(0);
    wait_done(3, 20);
    thread_count = 8'd8;
    for (int k = 0; k < 4; k++) begin
      check("done_held", done, 1);
      step(1);
    end
    start = 1'b0;
    step(1);
    check("done_drop_after_start_low", done, 0);
    step(1);
    check_queues("t0");

    // Both cores complete in the same cycle.
    delay[0] = 5; delay[1] = 4;
    exp_dispatch(0, 0, 4, 2);
    exp_dispatch(1, 1, 4, 3);
    exp_finish(10, 8);
    launch(8);
    wait_done(4, 60);
    start = 1'b0;
    step(2);
    check_queues("same_cycle");

    // Reset mid-RUN abandons the kernel.
    delay[0] = 5; delay[1] = 5;
    exp_dispatch(0, 0, 4, 2);
    exp_dispatch(1, 1, 4, 3);
    launch(8);
    step(5);
    reset = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    start = 1'b0;
    step(2);
    reset = 1'b1;
    step(3);
    check("idle_after_reset_done", done, 0);
    check("idle_after_reset_start", core_start, 0);
    check_queues("midrun");

    exp_dispatch(0, 0, 4, 2);
    exp_finish(10, 8);
    launch(4);
    wait_done(5, 60);
    start = 1'b0;
    step(2);
    check_queues("t4");

    // Single partial block, start dropped during RUN: 7 RUN cycles.
    delay[0] = 4;
    exp_dispatch(0, 0, 3, 2);
    exp_finish(9, 7);
    launch(3);
    step(3);
    start = 1'b0;
    wait_done(6, 60);
    check("done_pulse_falls", done, 0);
    check("perf_frozen", perf_cycles, pexp(7));
    step(2);
    check_queues("t3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dispatch.md
DISPATCH -- requirements
Module: dispatch

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of compute cores served.
REQ-002 SHALL have parameter THREADS_PER_BLOCK, default 4, maximum threads per block.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, kernel launch level.
REQ-006 SHALL have port thread_count, input, 8, total kernel threads, sampled on launch.
REQ-007 SHALL have port core_done, input, NUM_CORES, per-core block-complete flag, level-held by the core until its reset.
REQ-008 SHALL have port core_reset, output, NUM_CORES, per-core one-cycle reset pulse.
REQ-009 SHALL have port core_start, output, NUM_CORES, per-core start level.
REQ-010 SHALL have port core_block_id, output, NUM_CORES x 8, block index assigned to each core.
REQ-011 SHALL have port core_thread_count, output, NUM_CORES x ($clog2(THREADS_PER_BLOCK)+1), active threads in the assigned block.
REQ-012 SHALL have port done, output, 1, kernel complete.
REQ-013 SHALL have port perf_cycles, output, 16, launch-to-done cycle count.

Function
REQ-014 SHALL implement a top FSM with states IDLE, RUN and DONE.
REQ-015 IDLE: start=1 with thread_count>0 SHALL latch total_blocks = ceil(thread_count/THREADS_PER_BLOCK), clear dispatched and completed counters, and enter RUN.
REQ-016 IDLE: start=1 with thread_count=0 SHALL enter DONE directly; done rises the following cycle.
REQ-017 SHALL keep a lane FSM per core with states FREE, RESET and BUSY; every lane is FREE in IDLE.
REQ-018 RUN: when dispatched<total_blocks, the lowest-index FREE lane SHALL be chosen, with at most one dispatch per cycle.
REQ-019 The chosen lane SHALL get core_reset=1 for exactly that cycle; core_block_id=dispatched; dispatched increments; the lane moves to RESET.
REQ-020 core_thread_count SHALL be THREADS_PER_BLOCK, except for the final block when thread_count mod THREADS_PER_BLOCK is nonzero, where it is that remainder.
REQ-021 RESET SHALL go to BUSY after one cycle; core_start is 1 throughout BUSY; core_done is ignored while in RESET, because a stale done is cleared by the pulse.
REQ-022 BUSY with core_done=1 SHALL drop core_start next cycle, return the lane to FREE, and increment completed.
REQ-023 Completions on several lanes in the same cycle SHALL all be counted, adding popcount to completed.
REQ-024 A lane freed in cycle N SHALL be eligible for dispatch in cycle N+1, not N.
REQ-025 core_block_id and core_thread_count SHALL hold their values until that lane is next dispatched.
REQ-026 RUN SHALL enter DONE when completed == total_blocks; done=1 from the next cycle.
REQ-027 DONE SHALL hold done=1 while start=1 and ignore further launches; start=0 returns to IDLE, done=0 next cycle.
REQ-028 start deasserted during RUN SHALL NOT abort; the kernel runs to completion.
REQ-029 Counters SHALL be 8 bits; total_blocks never exceeds 64 for THREADS_PER_BLOCK>=4, so no wrap-around occurs.

Reset
REQ-030 On reset=0, asynchronously: FSM=IDLE, all lanes FREE, core_reset=0, core_start=0, core_block_id=0, core_thread_count=0, done=0, perf_cycles=0, counters=0.
REQ-031 Reset asserted mid-RUN SHALL abandon the kernel; after release the block waits in IDLE for a new start.

Configuration
REQ-032 With DISPATCH_PERF_CNT_EN defined, perf_cycles SHALL clear on launch, increment each cycle in RUN (saturating at 16'hFFFF), and freeze in DONE.
REQ-033 Without DISPATCH_PERF_CNT_EN, perf_cycles SHALL be constant 0 and no counter register is synthesized.

Verification
REQ-034 NUM_CORES=2, TPB=4, thread_count=8, each core asserts done 5 cycles after start -> cores 0/1 get block ids 0/1, thread count 4, done after both complete.
REQ-035 thread_count=10 -> 3 blocks; block 2 has core_thread_count=2 and is dispatched to the first freed core.
REQ-036 thread_count=0 -> no core_reset pulse, done=1 on cycle 2 after start.
REQ-037 Both cores assert core_done in the same cycle with 2 blocks -> completed=2, done asserted the next cycle.
REQ-038 Reset pulled low mid-RUN -> all outputs 0 immediately; a new start with thread_count=4 dispatches block 0 to core 0.
REQ-039 With DISPATCH_PERF_CNT_EN defined, a fixed 1-block run of 7 RUN cycles -> perf_cycles=7, held in DONE.
